// File: rtl/modulo_sekuencial.sv
// Sequential restoring divider: remainder (Dalja) and quotient (Heresi), one quotient bit per clock.
// Signed mode divides magnitudes and applies the stored result signs on the final step.
module modulo_sekuencial #(
  parameter  int WIDTH = 16,
  localparam int CNT_W = $clog2(WIDTH+1)
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic [WIDTH-1:0] Hyrja1,
  input  logic [WIDTH-1:0] Hyrja2,
  input  logic             Menyra,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] Dalja,
  output logic [WIDTH-1:0] Heresi,
  output logic             DivZero,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_rem, r_quo, r_dvs;
  logic [CNT_W-1:0] r_cnt;
  logic             r_qneg, r_rneg;

  logic             w_a_neg, w_b_neg, w_borrow, w_last;
  logic [WIDTH-1:0] w_a_abs, w_b_abs, w_rem_nxt, w_quo_nxt;
  logic [WIDTH:0]   w_sh, w_trial;

  assign w_a_neg = Menyra & Hyrja1[WIDTH-1];
  assign w_b_neg = Menyra & Hyrja2[WIDTH-1];
  assign w_a_abs = w_a_neg ? ('0 - Hyrja1) : Hyrja1;
  assign w_b_abs = w_b_neg ? ('0 - Hyrja2) : Hyrja2;

  // Shifted remainder is < 2*divisor, so the top bit of the (WIDTH+1)-bit trial is the borrow.
  assign w_sh      = {r_rem, r_quo[WIDTH-1]};
  assign w_trial   = w_sh - {1'b0, r_dvs};
  assign w_borrow  = w_trial[WIDTH];
  assign w_rem_nxt = w_borrow ? w_sh[WIDTH-1:0] : w_trial[WIDTH-1:0];
  assign w_quo_nxt = {r_quo[WIDTH-2:0], ~w_borrow};
  assign w_last    = (r_cnt == CNT_W'(WIDTH-1));

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state   <= S_IDLE;
      r_rem     <= '0;
      r_quo     <= '0;
      r_dvs     <= '0;
      r_cnt     <= '0;
      r_qneg    <= 1'b0;
      r_rneg    <= 1'b0;
      in_ready  <= 1'b0;
      Dalja     <= '0;
      Heresi    <= '0;
      DivZero   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          in_ready <= 1'b1;
          if (in_valid) begin
            in_ready <= 1'b0;
            if (Hyrja2 == '0) begin
              r_state   <= S_DONE;
              Dalja     <= Hyrja1;
              Heresi    <= '1;
              DivZero   <= 1'b1;
              out_valid <= 1'b1;
            end else begin
              r_state <= S_CALC;
              r_rem   <= '0;
              r_quo   <= w_a_abs;
              r_dvs   <= w_b_abs;
              r_cnt   <= '0;
              r_qneg  <= w_a_neg ^ w_b_neg;
              r_rneg  <= w_a_neg;
            end
          end
        end
        S_CALC: begin
          r_rem <= w_rem_nxt;
          r_quo <= w_quo_nxt;
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_state   <= S_DONE;
            Dalja     <= r_rneg ? ('0 - w_rem_nxt) : w_rem_nxt;
            Heresi    <= r_qneg ? ('0 - w_quo_nxt) : w_quo_nxt;
            DivZero   <= 1'b0;
            out_valid <= 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state   <= S_IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/modulo_sekuencial.md
Name: modulo_sekuencial

Overview:
Parametrised sequential divider/modulo unit. It computes Hyrja1 % Hyrja2 (remainder) and Hyrja1 / Hyrja2 (quotient) by restoring division, one quotient bit per clock. It supports unsigned and signed (two's-complement) modes and flags divide-by-zero. It sits behind the ALU operand bus and uses a valid/ready handshake on both input and output, so it can stall on downstream backpressure.

Parameters:
WIDTH, 16, operand/result width in bits (>= 2).
CNT_W, $clog2(WIDTH+1), iteration-counter width (derived, not overridden).

Ports:
Clock  input  1  rising-edge clock.
Reset_n  input  1  asynchronous, active-low reset.
Hyrja1  input  WIDTH  dividend.
Hyrja2  input  WIDTH  divisor.
Menyra  input  1  0 = unsigned, 1 = signed; sampled with the operands.
in_valid  input  1  operands valid.
in_ready  output  1  unit can accept operands.
Dalja  output  WIDTH  remainder.
Heresi  output  WIDTH  quotient.
DivZero  output  1  result was produced with Hyrja2 == 0.
out_valid  output  1  Dalja/Heresi/DivZero valid.
out_ready  input  1  consumer accepts the result.

Behaviour:
- Reset (Reset_n low, asynchronous): state IDLE; Dalja = 0, Heresi = 0, DivZero = 0, out_valid = 0; all internal registers cleared. A reset asserted mid-calculation aborts that calculation and produces no result. in_ready = 1 from the first edge after Reset_n rises.
- States:
  - IDLE: in_ready = 1.
  - CALC: in_ready = 0, out_valid = 0.
  - DONE: in_ready = 0, out_valid = 1.
- Accept: an edge in IDLE with in_valid = 1 captures Hyrja1, Hyrja2 and Menyra. Operand changes after the accept edge have no effect.
- IDLE -> CALC on accept when Hyrja2 != 0.
  - Signed mode: the magnitudes |Hyrja1| and |Hyrja2| are stored as WIDTH-bit unsigned values, so |MIN| = 2^(WIDTH-1). The result signs are also stored: quotient negative iff the operand signs differ; remainder takes the sign of the dividend.
  - Iteration counter is set to 0.
- CALC, each edge: one restoring step.
  - Shift {rem, quo} left by one.
  - Trial = rem - divisor, computed at WIDTH+1 bits.
  - If there is no borrow: rem = trial and the quotient LSB = 1.
  - Counter increments.
- CALC -> DONE on the edge that completes step WIDTH. On that same edge, Dalja and Heresi are registered with the sign fix-up applied (two's-complement negate where the stored sign is negative).
- Latency: out_valid rises exactly WIDTH edges after the accept edge.
- Divide-by-zero: IDLE -> DONE directly on the accept edge, so out_valid rises 1 edge after accept. Outputs: Dalja = Hyrja1 unchanged (in either mode), Heresi = all ones, DivZero = 1. For every non-zero divisor, DivZero = 0.
- Signed overflow (MIN / -1): Heresi = MIN (wraps), Dalja = 0, DivZero = 0.
- DONE:
  - Dalja, Heresi and DivZero are held stable while out_valid = 1 and out_ready = 0.
  - On an edge with out_ready = 1: DONE -> IDLE and out_valid -> 0.
  - in_ready stays 0 during DONE, so there is no same-cycle accept; the next accept is possible one edge later.
- in_valid is ignored outside IDLE.
- After the handshake, outputs retain their last values (out_valid = 0). Consumers qualify data with out_valid only.
- Unsigned results equal Verilog / and % on WIDTH-bit unsigned values. Signed results equal $signed / and % (truncation toward zero).

Test Plan:
- Unsigned, WIDTH = 16: Hyrja1 = 100, Hyrja2 = 7, Menyra = 0 -> out_valid exactly 16 edges after accept; Dalja = 2, Heresi = 14, DivZero = 0.
- Signed: Hyrja1 = 0xFFF9 (-7), Hyrja2 = 3, Menyra = 1 -> Dalja = 0xFFFF (-1), Heresi = 0xFFFE (-2). Then 7 % -3 -> Dalja = 1, Heresi = 0xFFFE.
- Divide-by-zero: Hyrja1 = 1234, Hyrja2 = 0 -> out_valid 1 edge after accept; Dalja = 1234, Heresi = 0xFFFF, DivZero = 1.
- Signed overflow: Hyrja1 = 0x8000, Hyrja2 = 0xFFFF, Menyra = 1 -> Heresi = 0x8000, Dalja = 0. Unsigned 0xFFFF % 0x0001 -> Dalja = 0, Heresi = 0xFFFF.
- Backpressure: hold out_ready = 0 for 5 cycles after out_valid, toggling in_valid and the operands -> outputs stable, in_ready = 0, no new accept. Raise out_ready -> out_valid drops next edge, in_ready = 1.
- Reset mid-CALC: assert Reset_n = 0 asynchronously 5 edges after accept -> Dalja, Heresi, DivZero and out_valid go to 0 immediately. After release, in_ready = 1 and a new 100 % 7 returns Dalja = 2 with correct 16-edge latency. Also run 2000 random vectors per mode against the Verilog / and % reference model.
